bram_stream_writer: RTL and testbench
=====================================

// Module: bram_stream_writer
// PURPOSE
//  Sink end of the o_valid/o_mem_data read-out stream of simple_bram_ctrl: captures a run of N
//  valid words and writes them into a true_dpbram port (normally port B) at consecutive
//  addresses from a start address, wrapping at MEM_SIZE. Reports progress, a running checksum
//  and overrun, so a read-out can be copied into a second BRAM region and checked.
// PARAMETERS
//  DWIDTH    16   data width, equals the BRAM word width
//  AWIDTH    7    address width; also the width of i_num_cnt
//  MEM_SIZE  128  BRAM depth in words; MEM_SIZE <= 2**AWIDTH
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  reset        in   1       synchronous, active-high reset
//  i_run        in   1       1-cycle start pulse, sampled only in IDLE
//  i_num_cnt    in   AWIDTH  words to capture, latched with i_run
//  i_start_addr in   AWIDTH  first BRAM address, latched with i_run; must be < MEM_SIZE
//  i_valid      in   1       input word strobe; no backpressure, must be accepted every cycle
//  i_data       in   DWIDTH  input word, qualified by i_valid
//  o_idle       out  1       state == IDLE
//  o_write      out  1       state == WRITE
//  o_done       out  1       1-cycle pulse, state == DONE
//  o_overrun    out  1       sticky: i_valid seen outside WRITE; cleared by accepted i_run
//  o_wr_cnt     out  AWIDTH  words accepted in the current/last run
//  o_checksum   out  DWIDTH  mod-2**DWIDTH sum of words accepted in the current/last run
//  addr1        out  AWIDTH  BRAM address
//  ce1          out  1       BRAM chip enable
//  we1          out  1       BRAM write enable
//  d1           out  DWIDTH  BRAM write data
// BEHAVIOUR
//  Reset: state=IDLE, o_idle=1, all other outputs 0, addr1/d1=0. Reset mid-run drops any
//   pending write: ce1/we1 are 0 in the cycle after reset is sampled high.
//  FSM: IDLE -> WRITE on i_run when i_num_cnt != 0. IDLE -> DONE on i_run when i_num_cnt == 0
//   (no BRAM access). WRITE -> DONE on the edge that accepts word number i_num_cnt.
//   DONE -> IDLE unconditionally after 1 cycle. i_run outside IDLE is ignored.
//  On an accepted i_run: clear o_wr_cnt, o_checksum and o_overrun; latch count and address.
//  Accept: i_valid=1 in WRITE. If a word is accepted at edge T, then from T to T+1:
//   ce1=we1=1, addr1=current address, d1=i_data. ce1/we1=0 in every other cycle
//   (registered outputs, 1-cycle latency). o_wr_cnt increments and o_checksum += i_data,
//   both visible after T.
//  Gaps in i_valid during WRITE stall without error; there is no timeout.
//  Address: after each accepted word, addr = addr+1, with MEM_SIZE-1 wrapping to 0.
//   Compare and reset, not a power-of-2 mask.
//  Last word: the final write (we1=1) and o_done=1 occupy the same cycle. o_idle=1 one cycle later.
//  i_valid in IDLE or DONE: the word is dropped and o_overrun is set, in the same edge as a
//   DONE->IDLE transition if the two coincide.
//  i_run and i_valid in the same IDLE cycle: the run starts, the word is dropped, o_overrun is set.
//  Checksum arithmetic is unsigned and wraps silently. o_wr_cnt never exceeds the latched count.
// STRUCTURE
//  Shared package/header: FSM state encodings (IDLE, WRITE, DONE; 2 bits) as localparams.
//   simple_bram_ctrl uses the same encodings.
//  Sub-module bram_addr_wrap_cnt (load, inc; wraps at MEM_SIZE) generates the address.
//   simple_bram_ctrl can reuse it.
//  No memory instance inside the block. Port A of the same true_dpbram is left free for readback.
// TESTING (bench: simple_bram_ctrl on port A streaming into this block on port B of a second
//  true_dpbram, DWIDTH=16, AWIDTH=7, MEM_SIZE=128)
//  1 Start=0, cnt=100, words 0..99 on 100 consecutive cycles -> addr 0..99 hold 0..99;
//    o_checksum=4950 (0x1356); o_wr_cnt=100; o_done pulses once in the cycle of the write to addr 99.
//  2 Same stimulus with i_valid dropping every 3rd cycle -> same memory contents and checksum,
//    o_done later, o_overrun=0.
//  3 Start=120, cnt=16, data 0xA000+k -> addr 120..127 then 0..7 hold the data in order;
//    no write to addr 8.
//  4 cnt=0 with i_run -> o_done high 1 cycle after i_run; ce1 never asserted; o_wr_cnt=0.
//  5 cnt=4, 6 valid words back-to-back -> 4 writes; o_overrun=1 after word 6;
//    next accepted i_run clears it.
//  6 reset pulsed after 10 of 50 words -> ce1=0 from the next cycle; all outputs at reset values;
//    a new run of cnt=5 completes normally.

Source files
------------

// File: rtl/bram_stream_writer_pkg.sv
// Shared definitions for the BRAM stream writer and its companion read controller.
//  - Default geometry (data width, address width, memory depth).
//  - FSM state encodings, kept identical to simple_bram_ctrl so both ends decode alike.
package bram_stream_writer_pkg;

  localparam int unsigned BSW_DWIDTH   = 16;
  localparam int unsigned BSW_AWIDTH   = 7;
  localparam int unsigned BSW_MEM_SIZE = 128;

  // Raw state encodings shared with simple_bram_ctrl
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_WRITE = ST_WRITE,
    S_DONE  = ST_DONE
  } bsw_state_e;

endpackage : bram_stream_writer_pkg

// File: rtl/bram_stream_writer_addr.sv
// bram_addr_wrap_cnt: BRAM address counter with explicit wrap at MEM_SIZE.
//  clk         in  clock
//  reset       in  synchronous active-high reset (address -> 0)
//  i_load      in  load i_load_addr (has priority over i_inc)
//  i_load_addr in  address to load
//  i_inc       in  advance address by one, MEM_SIZE-1 wraps to 0
//  o_addr      out current address (registered)
module bram_addr_wrap_cnt #(
  parameter int unsigned AWIDTH   = 7,
  parameter int unsigned MEM_SIZE = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [AWIDTH-1:0] i_load_addr,
  input  logic              i_inc,
  output logic [AWIDTH-1:0] o_addr
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

  logic [AWIDTH-1:0] r_addr;

  // Compare-and-reset wrap so non power-of-two depths work
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_addr;
    end else if (i_inc) begin
      r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + AWIDTH'(1);
    end
  end

  assign o_addr = r_addr;

endmodule : bram_addr_wrap_cnt

// File: rtl/bram_stream_writer.sv
// bram_stream_writer: captures a run of i_num_cnt valid words from a read-out stream and
// writes them to a BRAM port at consecutive (wrapping) addresses from i_start_addr.
//  clk, reset          clock, synchronous active-high reset
//  i_run               start pulse, only honoured in IDLE
//  i_num_cnt           words to capture (latched with i_run)
//  i_start_addr        first BRAM address (latched with i_run)
//  i_valid, i_data     input stream, no backpressure
//  o_idle/o_write/o_done  state flags (o_done is a 1-cycle pulse)
//  o_overrun           sticky, i_valid seen outside WRITE
//  o_wr_cnt            words accepted in current/last run
//  o_checksum          wrapping sum of accepted words
//  addr1/ce1/we1/d1    BRAM write port
module bram_stream_writer
  import bram_stream_writer_pkg::*;
#(
  parameter int unsigned DWIDTH   = BSW_DWIDTH,
  parameter int unsigned AWIDTH   = BSW_AWIDTH,
  parameter int unsigned MEM_SIZE = BSW_MEM_SIZE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run,
  input  logic [AWIDTH-1:0] i_num_cnt,
  input  logic [AWIDTH-1:0] i_start_addr,
  input  logic              i_valid,
  input  logic [DWIDTH-1:0] i_data,
  output logic              o_idle,
  output logic              o_write,
  output logic              o_done,
  output logic              o_overrun,
  output logic [AWIDTH-1:0] o_wr_cnt,
  output logic [DWIDTH-1:0] o_checksum,
  output logic [AWIDTH-1:0] addr1,
  output logic              ce1,
  output logic              we1,
  output logic [DWIDTH-1:0] d1
);

  bsw_state_e        r_state;
  logic [AWIDTH-1:0] r_num_cnt;
  logic [AWIDTH-1:0] r_wr_cnt;
  logic [DWIDTH-1:0] r_checksum;
  logic              r_idle;
  logic              r_write;
  logic              r_done;
  logic              r_overrun;
  logic [AWIDTH-1:0] r_addr1;
  logic              r_ce1;
  logic              r_we1;
  logic [DWIDTH-1:0] r_d1;

  logic [AWIDTH-1:0] w_addr;
  logic              w_load;
  logic              w_accept;
  logic              w_last;

  assign w_load   = (r_state == S_IDLE) && i_run;
  assign w_accept = (r_state == S_WRITE) && i_valid;
  assign w_last   = w_accept && ((r_wr_cnt + AWIDTH'(1)) == r_num_cnt);

  bram_addr_wrap_cnt #(
    .AWIDTH   (AWIDTH),
    .MEM_SIZE (MEM_SIZE)
  ) u_addr (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_load_addr (i_start_addr),
    .i_inc       (w_accept),
    .o_addr      (w_addr)
  );

  // Control FSM with registered status flags and BRAM write port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_num_cnt  <= '0;
      r_wr_cnt   <= '0;
      r_checksum <= '0;
      r_idle     <= 1'b1;
      r_write    <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
      r_addr1    <= '0;
      r_ce1      <= 1'b0;
      r_we1      <= 1'b0;
      r_d1       <= '0;
    end else begin
      r_ce1  <= 1'b0;
      r_we1  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_num_cnt  <= i_num_cnt;
            r_wr_cnt   <= '0;
            r_checksum <= '0;
            r_idle     <= 1'b0;
            if (i_num_cnt == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_WRITE;
              r_write <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (i_valid) begin
            r_ce1      <= 1'b1;
            r_we1      <= 1'b1;
            r_addr1    <= w_addr;
            r_d1       <= i_data;
            r_wr_cnt   <= r_wr_cnt + AWIDTH'(1);
            r_checksum <= r_checksum + i_data;
            // Final write and o_done share the same cycle
            if (w_last) begin
              r_state <= S_DONE;
              r_write <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_idle  <= 1'b1;
          r_write <= 1'b0;
        end
      endcase

      // A stray word wins over the clear from a coincident i_run
      if (i_valid && (r_state != S_WRITE)) begin
        r_overrun <= 1'b1;
      end else if (w_load) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_idle     = r_idle;
  assign o_write    = r_write;
  assign o_done     = r_done;
  assign o_overrun  = r_overrun;
  assign o_wr_cnt   = r_wr_cnt;
  assign o_checksum = r_checksum;
  assign addr1      = r_addr1;
  assign ce1        = r_ce1;
  assign we1        = r_we1;
  assign d1         = r_d1;

endmodule : bram_stream_writer

// File: tb/tb_bram_stream_writer.sv
// Bench for bram_stream_writer: directed cycle table, stream runs checked against an
// expected write list, and randomized runs.
module tb_bram_stream_writer;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 7;
  localparam int unsigned MS = 128;

  logic          clk;
  logic          reset;
  logic          i_run;
  logic [AW-1:0] i_num_cnt;
  logic [AW-1:0] i_start_addr;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_idle;
  logic          o_write;
  logic          o_done;
  logic          o_overrun;
  logic [AW-1:0] o_wr_cnt;
  logic [DW-1:0] o_checksum;
  logic [AW-1:0] addr1;
  logic          ce1;
  logic          we1;
  logic [DW-1:0] d1;

  bram_stream_writer #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_run        (i_run),
    .i_num_cnt    (i_num_cnt),
    .i_start_addr (i_start_addr),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_idle       (o_idle),
    .o_write      (o_write),
    .o_done       (o_done),
    .o_overrun    (o_overrun),
    .o_wr_cnt     (o_wr_cnt),
    .o_checksum   (o_checksum),
    .addr1        (addr1),
    .ce1          (ce1),
    .we1          (we1),
    .d1           (d1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // BRAM model on the write port plus a log of every write
  logic [DW-1:0] mem [MS];
  logic [AW-1:0] wlog_addr[$];
  logic [DW-1:0] wlog_data[$];
  always @(posedge clk) begin
    if (ce1 && we1) begin
      mem[addr1] = d1;
      wlog_addr.push_back(addr1);
      wlog_data.push_back(d1);
    end
  end

  // o_done pulse counter and alignment of the pulse with the final write
  int cur_cnt   = 0;
  int done_cnt  = 0;
  int align_err = 0;
  always @(negedge clk) begin
    if (!reset && o_done) begin
      done_cnt++;
      if (cur_cnt != 0 && !(ce1 && we1)) align_err++;
      if (cur_cnt == 0 && (ce1 || we1)) align_err++;
    end
  end

  // Output bundle: {idle,write,done,ce1,we1,overrun,addr1,d1,wr_cnt,checksum}
  function automatic logic [63:0] act_bundle();
    return {12'd0, o_idle, o_write, o_done, ce1, we1, o_overrun, addr1, d1, o_wr_cnt, o_checksum};
  endfunction

  function automatic logic [63:0] exp_bundle(input logic ei, input logic ew, input logic ed,
                                             input logic ec, input logic eo, input int ea,
                                             input int edd, input int ewc, input int eck);
    return {12'd0, ei, ew, ed, ec, ec, eo, AW'(ea), DW'(edd), AW'(ewc), DW'(eck)};
  endfunction

  typedef struct {
    logic          run;
    logic [AW-1:0] cnt;
    logic [AW-1:0] start;
    logic          valid;
    logic [DW-1:0] data;
    logic [63:0]   exp;
  } vec_t;

  function automatic vec_t mk(input logic r, input int c, input int s, input logic v, input int d,
                              input logic [63:0] e);
    vec_t t;
    t.run = r; t.cnt = AW'(c); t.start = AW'(s); t.valid = v; t.data = DW'(d); t.exp = e;
    return t;
  endfunction

  // One capture run: expected writes are (start+k) mod MS <- word k, in order
  task automatic run_stream(input int start, input int cnt, input int dmode, input int gmode,
                            input int extra, input string tag);
    logic [DW-1:0] words[$];
    logic [DW-1:0] w;
    int unsigned   sum;
    int            base, done0, align0, cyc, t, errs, ea;
    words = {};
    sum   = 0;
    for (int k = 0; k < cnt; k++) begin
      case (dmode)
        0:       w = DW'(k);
        1:       w = DW'(32'hA000 + k);
        default: w = DW'($urandom);
      endcase
      words.push_back(w);
      sum += 32'(w);
    end
    base   = wlog_addr.size();
    done0  = done_cnt;
    align0 = align_err;
    cur_cnt = cnt;

    @(negedge clk);
    i_run = 1'b1; i_num_cnt = AW'(cnt); i_start_addr = AW'(start); i_valid = 1'b0;
    @(negedge clk);
    i_run = 1'b0;
    check({tag, "_start_clear"}, {61'd0, o_overrun, |o_wr_cnt, |o_checksum}, 64'd0);

    cyc = 0;
    for (int k = 0; k < cnt; k++) begin
      while ((gmode == 1 && (cyc % 3) == 2) || (gmode == 2 && $urandom_range(0, 3) == 0)) begin
        i_valid = 1'b0;
        @(negedge clk);
        cyc++;
      end
      i_valid = 1'b1;
      i_data  = words[k];
      @(negedge clk);
      cyc++;
    end
    for (int e = 0; e < extra; e++) begin
      i_valid = 1'b1;
      i_data  = DW'($urandom);
      @(negedge clk);
    end
    i_valid = 1'b0;

    t = 0;
    while (!o_idle && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_idle_reached"}, 64'(o_idle), 64'd1);

    check({tag, "_write_count"}, 64'(wlog_addr.size() - base), 64'(cnt));
    errs = 0;
    for (int k = 0; k < cnt && (base + k) < wlog_addr.size(); k++) begin
      ea = (start + k) % MS;
      if (wlog_addr[base+k] != AW'(ea) || wlog_data[base+k] != words[k] || mem[ea] != words[k]) begin
        if (errs == 0)
          $display("FAIL %s_write_seq: write %0d addr %0d data 0x%0h, expected addr %0d data 0x%0h",
                   tag, k, wlog_addr[base+k], wlog_data[base+k], ea, words[k]);
        errs++;
      end
    end
    check({tag, "_write_seq_errors"}, 64'(errs), 64'd0);
    check({tag, "_wr_cnt"}, 64'(o_wr_cnt), 64'(cnt));
    check({tag, "_checksum"}, 64'(o_checksum), 64'(DW'(sum)));
    check({tag, "_overrun"}, 64'(o_overrun), 64'(extra > 0));
    check({tag, "_done_pulses"}, 64'(done_cnt - done0), 64'd1);
    check({tag, "_done_align"}, 64'(align_err - align0), 64'd0);
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b1; i_run = 1'b0; i_num_cnt = '0; i_start_addr = '0; i_valid = 1'b0; i_data = '0;
    for (int a = 0; a < MS; a++) mem[a] = '0;
    repeat (2) @(negedge clk);
    check("reset_state", act_bundle(), exp_bundle(1, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b0;

    // Cycle table: wrap 126->127->0, gap, overrun in DONE, zero count, i_run in DONE,
    // run with coincident stray word, i_run ignored during WRITE
    vecs.push_back(mk(1, 3, 126, 0, 0,       exp_bundle(0, 1, 0, 0, 0, 0,   0,      0, 0)));
    vecs.push_back(mk(0, 0, 0,   1, 16'h0010, exp_bundle(0, 1, 0, 1, 0, 126, 'h0010, 1, 'h0010)));
    vecs.push_back(mk(0, 0, 0,   0, 0,       exp_bundle(0, 1, 0, 0, 0, 126, 'h0010, 1, 'h0010)));
    vecs.push_back(mk(0, 0, 0,   1, 16'h0020, exp_bundle(0, 1, 0, 1, 0, 127, 'h0020, 2, 'h0030)));
    vecs.push_back(mk(0, 0, 0,   1, 16'hFFF0, exp_bundle(0, 0, 1, 1, 0, 0,   'hFFF0, 3, 'h0020)));
    vecs.push_back(mk(0, 0, 0,   1, 16'h1234, exp_bundle(1, 0, 0, 0, 1, 0,   'hFFF0, 3, 'h0020)));
    vecs.push_back(mk(0, 0, 0,   0, 0,       exp_bundle(1, 0, 0, 0, 1, 0,   'hFFF0, 3, 'h0020)));
    vecs.push_back(mk(1, 0, 5,   0, 0,       exp_bundle(0, 0, 1, 0, 0, 0,   'hFFF0, 0, 0)));
    vecs.push_back(mk(1, 2, 10,  0, 0,       exp_bundle(1, 0, 0, 0, 0, 0,   'hFFF0, 0, 0)));
    vecs.push_back(mk(1, 2, 10,  1, 16'h5555, exp_bundle(0, 1, 0, 0, 1, 0,   'hFFF0, 0, 0)));
    vecs.push_back(mk(0, 0, 0,   1, 16'h0001, exp_bundle(0, 1, 0, 1, 1, 10,  'h0001, 1, 1)));
    vecs.push_back(mk(1, 5, 20,  1, 16'h0002, exp_bundle(0, 0, 1, 1, 1, 11,  'h0002, 2, 3)));
    vecs.push_back(mk(0, 0, 0,   0, 0,       exp_bundle(1, 0, 0, 0, 1, 11,  'h0002, 2, 3)));
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      i_run = vecs[i].run; i_num_cnt = vecs[i].cnt; i_start_addr = vecs[i].start;
      i_valid = vecs[i].valid; i_data = vecs[i].data;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), act_bundle(), vecs[i].exp);
    end
    @(negedge clk);
    i_run = 1'b0; i_valid = 1'b0;

    run_stream(0,   100, 0, 0, 0, "seq100");
    check("seq100_checksum_const", 64'(o_checksum), 64'h1356);
    run_stream(0,   100, 0, 1, 0, "gap3");
    run_stream(120, 16,  1, 0, 0, "wrap");
    run_stream(7,   0,   0, 0, 0, "zero");
    run_stream(30,  4,   2, 0, 2, "over");
    run_stream(40,  3,   2, 0, 0, "clear");

    // Reset in the middle of a 50-word run
    @(negedge clk);
    i_run = 1'b1; i_num_cnt = AW'(50); i_start_addr = '0;
    @(negedge clk);
    i_run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      i_valid = 1'b1; i_data = DW'(16'h7700 + k);
      @(negedge clk);
    end
    i_data = 16'h77FF;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_reset", act_bundle(), exp_bundle(1, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0; i_valid = 1'b0;
    run_stream(0, 5, 2, 0, 0, "after_reset");

    for (int r = 0; r < 25; r++) begin
      run_stream(int'($urandom_range(0, MS - 1)), int'($urandom_range(0, MS - 1)), 2, 2,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                 $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule : tb_bram_stream_writer
